arbitro_cajero: RTL and testbench

ARBITRO_CAJERO -- requirements
Module: arbitro_cajero

---
 rtl/arbitro_cajero.sv | 160 ++++++++++++++++
 tb/tb_arbitro_cajero.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/arbitro_cajero.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_cajero
// Purpose  : Round-robin arbiter that shares one cajero core among 4 terminals.
// Revision : 1.0 - initial release
// ============================================================================
module arbitro_cajero #(
  parameter logic [7:0] TIMEOUT_CICLOS = 8'd200
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] SOLICITUD,
  input  logic       ACTIVIDAD,
  input  logic       SESION_FIN,
  output logic [3:0] CONCESION,
  output logic [1:0] TERM_ACTIVA,
  output logic       TARJETA_CORE,
  output logic       OCUPADO,
  output logic       TIEMPO_AGOTADO
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_INICIO  = 2'd1,
    S_SESION  = 2'd2,
    S_LIBERAR = 2'd3
  } estado_t;

  localparam logic [7:0] C_LIMITE = TIMEOUT_CICLOS - 8'd1;

  estado_t    r_estado;
  logic [1:0] r_ultimo;
  logic [7:0] r_contador;
  logic [3:0] r_concesion;
  logic [1:0] r_term_activa;
  logic       r_tarjeta_core;
  logic       r_ocupado;
  logic       r_tiempo_agotado;

  estado_t    w_estado_sig;
  logic [1:0] w_ultimo;
  logic [7:0] w_contador;
  logic [3:0] w_concesion;
  logic [1:0] w_term_activa;
  logic       w_tarjeta_core;
  logic       w_ocupado;
  logic       w_tiempo_agotado;
  logic [1:0] w_ganador;
  logic       w_fin_sesion;
  logic       w_limite;

  // Scan starts just after the last winner and wraps back onto it last.
  function automatic logic [1:0] f_round_robin(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign w_ganador    = f_round_robin(SOLICITUD, r_ultimo);
  assign w_fin_sesion = SESION_FIN || !SOLICITUD[r_term_activa];
  assign w_limite     = (r_contador == C_LIMITE) && !ACTIVIDAD;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_estado         <= S_IDLE;
      r_ultimo         <= 2'd3;
      r_contador       <= 8'd0;
      r_concesion      <= 4'b0000;
      r_term_activa    <= 2'd0;
      r_tarjeta_core   <= 1'b0;
      r_ocupado        <= 1'b0;
      r_tiempo_agotado <= 1'b0;
    end else begin
      r_estado         <= w_estado_sig;
      r_ultimo         <= w_ultimo;
      r_contador       <= w_contador;
      r_concesion      <= w_concesion;
      r_term_activa    <= w_term_activa;
      r_tarjeta_core   <= w_tarjeta_core;
      r_ocupado        <= w_ocupado;
      r_tiempo_agotado <= w_tiempo_agotado;
    end
  end

  // Output values are computed for the state being entered so they register on the same edge.
  always_comb begin
    w_estado_sig     = r_estado;
    w_ultimo         = r_ultimo;
    w_contador       = 8'd0;
    w_concesion      = r_concesion;
    w_term_activa    = r_term_activa;
    w_tarjeta_core   = 1'b0;
    w_ocupado        = r_ocupado;
    w_tiempo_agotado = 1'b0;

    case (r_estado)
      S_IDLE: begin
        w_concesion = 4'b0000;
        w_ocupado   = 1'b0;
        if (SOLICITUD != 4'b0000) begin
          w_estado_sig   = S_INICIO;
          w_ultimo       = w_ganador;
          w_concesion    = 4'b0001 << w_ganador;
          w_term_activa  = w_ganador;
          w_ocupado      = 1'b1;
          w_tarjeta_core = 1'b1;
        end
      end

      S_INICIO: begin
        w_estado_sig = S_SESION;
      end

      S_SESION: begin
        w_contador = ACTIVIDAD ? 8'd0 : r_contador + 8'd1;
        // A normal end or card removal takes priority over the timeout pulse.
        if (w_fin_sesion) begin
          w_estado_sig = S_LIBERAR;
          w_concesion  = 4'b0000;
          w_ocupado    = 1'b0;
        end else if (w_limite) begin
          w_estado_sig     = S_LIBERAR;
          w_concesion      = 4'b0000;
          w_ocupado        = 1'b0;
          w_tiempo_agotado = 1'b1;
        end
      end

      S_LIBERAR: begin
        w_estado_sig = S_IDLE;
        w_concesion  = 4'b0000;
        w_ocupado    = 1'b0;
      end

      default: begin
        w_estado_sig = S_IDLE;
        w_concesion  = 4'b0000;
        w_ocupado    = 1'b0;
      end
    endcase
  end

  assign CONCESION      = r_concesion;
  assign TERM_ACTIVA    = r_term_activa;
  assign TARJETA_CORE   = r_tarjeta_core;
  assign OCUPADO        = r_ocupado;
  assign TIEMPO_AGOTADO = r_tiempo_agotado;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_cajero.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbitro_cajero
// Purpose  : Directed vector-table bench for arbitro_cajero (TIMEOUT_CICLOS=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_arbitro_cajero;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] SOLICITUD;
  logic       ACTIVIDAD;
  logic       SESION_FIN;
  logic [3:0] CONCESION;
  logic [1:0] TERM_ACTIVA;
  logic       TARJETA_CORE;
  logic       OCUPADO;
  logic       TIEMPO_AGOTADO;

  int n_pass  = 0;
  int n_total = 0;

  // Observation vector: {CONCESION, TERM_ACTIVA, TARJETA_CORE, OCUPADO, TIEMPO_AGOTADO}
  localparam logic [8:0] M_ALL  = 9'h1FF;
  localparam logic [8:0] M_BUSY = 9'b0_0000_0011;

  typedef struct {
    logic [3:0] sol;
    logic       act;
    logic       fin;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  arbitro_cajero #(.TIMEOUT_CICLOS(8'd10)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .SOLICITUD     (SOLICITUD),
    .ACTIVIDAD     (ACTIVIDAD),
    .SESION_FIN    (SESION_FIN),
    .CONCESION     (CONCESION),
    .TERM_ACTIVA   (TERM_ACTIVA),
    .TARJETA_CORE  (TARJETA_CORE),
    .OCUPADO       (OCUPADO),
    .TIEMPO_AGOTADO(TIEMPO_AGOTADO)
  );

  always #5 CLK = ~CLK;

  function automatic logic [8:0] obs();
    return {CONCESION, TERM_ACTIVA, TARJETA_CORE, OCUPADO, TIEMPO_AGOTADO};
  endfunction

  function automatic vec_t mk(input logic [3:0] sol, input logic act, input logic fin,
                              input logic [3:0] conc, input logic [1:0] term,
                              input logic tarj, input logic ocup, input logic tiempo);
    vec_t v;
    v.sol = sol;
    v.act = act;
    v.fin = fin;
    v.exp = {conc, term, tarj, ocup, tiempo};
    return v;
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp,
                       input logic [8:0] mask);
    n_total++;
    if ((got & mask) === (exp & mask)) n_pass++;
    else $display("FAIL %s: got %b required %b (mask %b) at %0t", name, got, exp, mask, $time);
  endtask

  task automatic step(input logic [3:0] sol, input logic act, input logic fin);
    SOLICITUD  = sol;
    ACTIVIDAD  = act;
    SESION_FIN = fin;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET      = 1'b1;
    SOLICITUD  = 4'b0000;
    ACTIVIDAD  = 1'b0;
    SESION_FIN = 1'b0;
    @(posedge CLK);
    #1;
    check("reset_state", obs(), 9'b0, M_ALL);
    RESET = 1'b0;

    // Single request, round-robin sweep, card removal, persistent requester.
    tbl.push_back(mk(4'b0000, 0, 0, 4'b0000, 2'd0, 0, 0, 0));
    tbl.push_back(mk(4'b0001, 0, 0, 4'b0001, 2'd0, 1, 1, 0));
    tbl.push_back(mk(4'b0001, 0, 0, 4'b0001, 2'd0, 0, 1, 0));
    tbl.push_back(mk(4'b0001, 0, 1, 4'b0000, 2'd0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 4'b0000, 2'd0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 4'b0000, 2'd0, 0, 0, 0));
    tbl.push_back(mk(4'b1111, 0, 0, 4'b0010, 2'd1, 1, 1, 0));
    tbl.push_back(mk(4'b1111, 0, 1, 4'b0010, 2'd1, 0, 1, 0));
    tbl.push_back(mk(4'b1111, 0, 1, 4'b0000, 2'd1, 0, 0, 0));
    tbl.push_back(mk(4'b1111, 0, 0, 4'b0000, 2'd1, 0, 0, 0));
    tbl.push_back(mk(4'b1111, 0, 0, 4'b0100, 2'd2, 1, 1, 0));
    tbl.push_back(mk(4'b1111, 0, 0, 4'b0100, 2'd2, 0, 1, 0));
    tbl.push_back(mk(4'b1111, 0, 1, 4'b0000, 2'd2, 0, 0, 0));
    tbl.push_back(mk(4'b1111, 0, 0, 4'b0000, 2'd2, 0, 0, 0));
    tbl.push_back(mk(4'b1111, 0, 0, 4'b1000, 2'd3, 1, 1, 0));
    tbl.push_back(mk(4'b1111, 1, 0, 4'b1000, 2'd3, 0, 1, 0));
    tbl.push_back(mk(4'b1111, 0, 1, 4'b0000, 2'd3, 0, 0, 0));
    tbl.push_back(mk(4'b1111, 0, 0, 4'b0000, 2'd3, 0, 0, 0));
    tbl.push_back(mk(4'b1111, 0, 0, 4'b0001, 2'd0, 1, 1, 0));
    tbl.push_back(mk(4'b1111, 0, 0, 4'b0001, 2'd0, 0, 1, 0));
    tbl.push_back(mk(4'b1110, 0, 0, 4'b0000, 2'd0, 0, 0, 0));
    tbl.push_back(mk(4'b1110, 0, 0, 4'b0000, 2'd0, 0, 0, 0));
    tbl.push_back(mk(4'b1110, 0, 0, 4'b0010, 2'd1, 1, 1, 0));
    tbl.push_back(mk(4'b1110, 0, 0, 4'b0010, 2'd1, 0, 1, 0));
    tbl.push_back(mk(4'b1110, 0, 1, 4'b0000, 2'd1, 0, 0, 0));
    tbl.push_back(mk(4'b1100, 0, 0, 4'b0000, 2'd1, 0, 0, 0));
    tbl.push_back(mk(4'b1100, 0, 0, 4'b0100, 2'd2, 1, 1, 0));
    tbl.push_back(mk(4'b1100, 0, 0, 4'b0100, 2'd2, 0, 1, 0));
    tbl.push_back(mk(4'b1000, 0, 0, 4'b0000, 2'd2, 0, 0, 0));
    tbl.push_back(mk(4'b1000, 0, 0, 4'b0000, 2'd2, 0, 0, 0));
    tbl.push_back(mk(4'b1000, 0, 0, 4'b1000, 2'd3, 1, 1, 0));
    tbl.push_back(mk(4'b1000, 0, 0, 4'b1000, 2'd3, 0, 1, 0));
    tbl.push_back(mk(4'b1000, 0, 1, 4'b0000, 2'd3, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 4'b0000, 2'd3, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 4'b0000, 2'd3, 0, 0, 0));
    tbl.push_back(mk(4'b0100, 0, 0, 4'b0100, 2'd2, 1, 1, 0));
    tbl.push_back(mk(4'b0100, 0, 0, 4'b0100, 2'd2, 0, 1, 0));
    tbl.push_back(mk(4'b0100, 0, 1, 4'b0000, 2'd2, 0, 0, 0));
    tbl.push_back(mk(4'b0100, 0, 0, 4'b0000, 2'd2, 0, 0, 0));
    tbl.push_back(mk(4'b0100, 0, 0, 4'b0100, 2'd2, 1, 1, 0));
    tbl.push_back(mk(4'b0100, 0, 0, 4'b0100, 2'd2, 0, 1, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 4'b0000, 2'd2, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 0, 4'b0000, 2'd2, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].sol, tbl[i].act, tbl[i].fin);
      check($sformatf("vec[%0d]", i), obs(), tbl[i].exp, M_ALL);
    end

    // Timeout with no activity: pulse 10 cycles after SESION entry.
    step(4'b0001, 0, 0);
    check("to_inicio", obs(), {4'b0001, 2'd0, 3'b110}, M_ALL);
    step(4'b0001, 0, 0);
    check("to_sesion", obs(), {4'b0001, 2'd0, 3'b010}, M_ALL);
    for (int i = 1; i <= 9; i++) begin
      step(4'b0001, 0, 0);
      check($sformatf("to_wait[%0d]", i), obs(), 9'b0_0000_0010, M_BUSY);
    end
    step(4'b0001, 0, 0);
    check("to_pulse", obs(), {4'b0000, 2'd0, 3'b001}, M_ALL);
    step(4'b0000, 0, 0);
    check("to_pulse_end", obs(), {4'b0000, 2'd0, 3'b000}, M_ALL);

    // Periodic activity holds the session; activity at the limit clears; SESION_FIN at the limit releases quietly.
    step(4'b0001, 0, 0);
    check("act_inicio", obs(), {4'b0001, 2'd0, 3'b110}, M_ALL);
    step(4'b0001, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(4'b0001, (i % 5) == 4, 0);
      check($sformatf("act_hold[%0d]", i), obs(), 9'b0_0000_0010, M_BUSY);
    end
    for (int i = 0; i < 9; i++) step(4'b0001, 0, 0);
    check("act_pre_limit", obs(), 9'b0_0000_0010, M_BUSY);
    step(4'b0001, 1, 0);
    check("act_at_limit", obs(), {4'b0001, 2'd0, 3'b010}, M_ALL);
    for (int i = 0; i < 9; i++) step(4'b0001, 0, 0);
    check("act_pre_limit2", obs(), 9'b0_0000_0010, M_BUSY);
    step(4'b0001, 0, 1);
    check("fin_at_limit", obs(), {4'b0000, 2'd0, 3'b000}, M_ALL);
    step(4'b0000, 0, 0);
    check("fin_at_limit_idle", obs(), {4'b0000, 2'd0, 3'b000}, M_ALL);

    // Asynchronous reset mid-session, then arbitration restarts from terminal 0.
    step(4'b0100, 0, 0);
    check("rst_inicio", obs(), {4'b0100, 2'd2, 3'b110}, M_ALL);
    step(4'b0100, 0, 0);
    check("rst_sesion", obs(), {4'b0100, 2'd2, 3'b010}, M_ALL);
    #2;
    RESET = 1'b1;
    #1;
    check("rst_async", obs(), 9'b0, M_ALL);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    step(4'b1010, 0, 0);
    check("rst_first_grant", obs(), {4'b0010, 2'd1, 3'b110}, M_ALL);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
